qam_mapper: RTL and testbench

- Transmit-side symbol mapper: the inverse of SDMOD.
- Accepts a serial hard-bit stream with a valid strobe and groups the bits per symbol.
- Emits 12-bit signed I/Q constellation points with a valid strobe; output feeds the pilot/subcarrier assembly ahead of the IFFT.
- Works in frames of a fixed symbol count; modulation mode is latched per frame.

---
 rtl/qam_mapper_pkg.sv | 13 +
 rtl/qam_sym_lut.sv | 37 +++
 rtl/qam_mapper.sv | 133 +++++++++++++
 tb/tb_qam_mapper.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/qam_mapper_pkg.sv
// Shared constants for the QAM symbol mapper: mode encoding, constellation levels and I/Q width.
package qam_mapper_pkg;

    localparam logic MODE_QPSK  = 1'b0;
    localparam logic MODE_16QAM = 1'b1;

    localparam int QPSK_LVL = 1024;
    localparam int QAM16_HI = 1023;
    localparam int QAM16_LO = 341;

    localparam int QAM_DW = 12;

endpackage

// File: rtl/qam_sym_lut.sv
// Pure combinational constellation lookup: symbol bits (b0 in sym_i[3]) to signed I/Q values.
// The 16-QAM path exists only when QAM_MAPPER_16QAM_EN is defined.
module qam_sym_lut
    import qam_mapper_pkg::*;
#(
    parameter int DW = QAM_DW
) (
    input  logic [3:0]    sym_i,
    input  logic          mode_i,
    output logic [DW-1:0] re_o,
    output logic [DW-1:0] im_o
);

    function automatic logic [DW-1:0] level(input logic neg, input int mag);
        return neg ? DW'(-mag) : DW'(mag);
    endfunction

`ifdef QAM_MAPPER_16QAM_EN
    always_comb begin
        re_o = level(sym_i[3], QPSK_LVL);
        im_o = level(sym_i[2], QPSK_LVL);
        if (mode_i == MODE_16QAM) begin
            re_o = level(sym_i[3], sym_i[2] ? QAM16_LO : QAM16_HI);
            im_o = level(sym_i[1], sym_i[0] ? QAM16_LO : QAM16_HI);
        end
    end
`else
    logic unused_lut;
    assign unused_lut = ^{mode_i, sym_i[1:0]};

    always_comb begin
        re_o = level(sym_i[3], QPSK_LVL);
        im_o = level(sym_i[2], QPSK_LVL);
    end
`endif

endmodule

// File: rtl/qam_mapper.sv
// Serial-bit to QPSK/16-QAM symbol mapper with per-frame mode latch and SOF/EOF flags.
// 16-QAM support is compiled in only when QAM_MAPPER_16QAM_EN is defined.
module qam_mapper
    import qam_mapper_pkg::*;
#(
    parameter int FRAME_LEN = 512,
    parameter int DW        = QAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          di,
    input  logic          di_vld,
    input  logic          mode,
    output logic [DW-1:0] do_re,
    output logic [DW-1:0] do_im,
    output logic          do_vld,
    output logic          do_sof,
    output logic          do_eof
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

    logic          state_q, state_d;
    logic [1:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    sh_q, sh_d;
    logic [11:0]   sym_cnt_q, sym_cnt_d;
    logic [DW-1:0] re_q, re_d, im_q, im_d;
    logic          vld_q, vld_d, sof_q, sof_d, eof_q, eof_d;
    logic          mode_eff, last_bit;
    logic [3:0]    sym;
    logic [DW-1:0] lut_re, lut_im;

`ifdef QAM_MAPPER_16QAM_EN
    logic mode_q, mode_d;

    // In IDLE the incoming bit opens a frame, so the live mode input applies to it.
    assign mode_eff = (state_q == ST_IDLE) ? mode : mode_q;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign mode_eff    = MODE_QPSK;
`endif

    assign last_bit = di_vld && (bit_cnt_q == ((mode_eff == MODE_16QAM) ? 2'd3 : 2'd1));
    assign sym      = (mode_eff == MODE_16QAM) ? {sh_q, di} : {sh_q[0], di, 2'b00};

    qam_sym_lut #(
        .DW (DW)
    ) u_lut (
        .sym_i  (sym),
        .mode_i (mode_eff),
        .re_o   (lut_re),
        .im_o   (lut_im)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        sym_cnt_d = sym_cnt_q;
        re_d      = re_q;
        im_d      = im_q;
        vld_d     = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
`ifdef QAM_MAPPER_16QAM_EN
        mode_d    = mode_q;
`endif
        if (di_vld) begin
            sh_d = {sh_q[1:0], di};
            if (state_q == ST_IDLE) begin
                state_d = ST_ACTIVE;
`ifdef QAM_MAPPER_16QAM_EN
                mode_d  = mode;
`endif
            end
            if (last_bit) begin
                bit_cnt_d = 2'd0;
                vld_d     = 1'b1;
                re_d      = lut_re;
                im_d      = lut_im;
                sof_d     = (sym_cnt_q == 12'd0);
                eof_d     = (sym_cnt_q == 12'(FRAME_LEN - 1));
                if (eof_d) begin
                    sym_cnt_d = 12'd0;
                    state_d   = ST_IDLE;
                end else begin
                    sym_cnt_d = sym_cnt_q + 12'd1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 2'd0;
            sh_q      <= 3'd0;
            sym_cnt_q <= 12'd0;
            re_q      <= '0;
            im_q      <= '0;
            vld_q     <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
`ifdef QAM_MAPPER_16QAM_EN
            mode_q    <= MODE_QPSK;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            sym_cnt_q <= sym_cnt_d;
            re_q      <= re_d;
            im_q      <= im_d;
            vld_q     <= vld_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
`ifdef QAM_MAPPER_16QAM_EN
            mode_q    <= mode_d;
`endif
        end
    end

    assign do_re  = re_q;
    assign do_im  = im_q;
    assign do_vld = vld_q;
    assign do_sof = sof_q;
    assign do_eof = eof_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Scoreboard bench for qam_mapper: a frame/bit-list reference model queues expected symbols,
// a negedge monitor checks them; a second FRAME_LEN=1 instance checks the SOF/EOF corner.
module tb_qam_mapper;
    import qam_mapper_pkg::*;

    localparam int FL = 4;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          di = 1'b0;
    logic          di_vld = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] do_re, do_im, re1, im1;
    logic          do_vld, do_sof, do_eof, vld1, sof1, eof1;

    qam_mapper #(.FRAME_LEN(FL), .DW(DW)) dut (
        .clk(clk), .rst(rst), .di(di), .di_vld(di_vld), .mode(mode),
        .do_re(do_re), .do_im(do_im), .do_vld(do_vld), .do_sof(do_sof), .do_eof(do_eof)
    );

    qam_mapper #(.FRAME_LEN(1), .DW(DW)) dut1 (
        .clk(clk), .rst(rst), .di(di), .di_vld(di_vld), .mode(mode),
        .do_re(re1), .do_im(im1), .do_vld(vld1), .do_sof(sof1), .do_eof(eof1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int re;
        int im;
        bit sof;
        bit eof;
        int cyc;
    } exp_t;
    exp_t q[$];

    // Reference model state: one frame at a time, bits of the open symbol kept as a list.
    bit m_in_frame = 1'b0;
    bit m_mode16 = 1'b0;
    int m_cnt = 0;
    bit m_bits[$];
    int last_re = 0;
    int last_im = 0;

    function automatic int level(input bit neg, input int mag);
        return neg ? -mag : mag;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_bit(input bit b, input bit m);
        exp_t e;
        int bps;
        if (!m_in_frame) begin
            m_in_frame = 1'b1;
`ifdef QAM_MAPPER_16QAM_EN
            m_mode16 = m;
`else
            m_mode16 = 1'b0;
`endif
        end
        m_bits.push_back(b);
        bps = m_mode16 ? 4 : 2;
        if (m_bits.size() == bps) begin
            if (m_mode16) begin
                e.re = level(m_bits[0], m_bits[1] ? QAM16_LO : QAM16_HI);
                e.im = level(m_bits[2], m_bits[3] ? QAM16_LO : QAM16_HI);
            end else begin
                e.re = level(m_bits[0], QPSK_LVL);
                e.im = level(m_bits[1], QPSK_LVL);
            end
            e.sof = (m_cnt == 0);
            e.eof = (m_cnt == FL - 1);
            e.cyc = cyc + 1;
            q.push_back(e);
            m_bits.delete();
            if (e.eof) begin
                m_cnt = 0;
                m_in_frame = 1'b0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic drive_bit(input bit b, input bit m);
        di = b;
        mode = m;
        di_vld = 1'b1;
        model_bit(b, m);
        @(posedge clk);
        #1;
        di_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && !rst) begin
            if (do_vld) begin
                if (q.size() == 0) begin
                    check("spurious_vld", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("do_re", int'($signed(do_re)), e.re);
                    check("do_im", int'($signed(do_im)), e.im);
                    check("do_sof", int'(do_sof), int'(e.sof));
                    check("do_eof", int'(do_eof), int'(e.eof));
                    check("latency", cyc, e.cyc);
                    last_re = e.re;
                    last_im = e.im;
                end
            end else begin
                check("flags_idle", int'({do_sof, do_eof}), 0);
                check("hold_re", int'($signed(do_re)), last_re);
                check("hold_im", int'($signed(do_im)), last_im);
            end
            if (vld1) check("fl1_sof_eof", int'({sof1, eof1}), 3);
            else check("fl1_flags_idle", int'({sof1, eof1}), 0);
        end
    end

    initial begin
        bit t1[8];
        bit t2[8];
        t1 = '{0, 0, 0, 1, 1, 0, 1, 1};
        t2 = '{1, 1, 0, 0, 0, 0, 1, 1};

        idle(3);
        rst = 1'b0;
        check("rst_re", int'(do_re), 0);
        check("rst_im", int'(do_im), 0);
        check("rst_vld", int'(do_vld), 0);
        check("rst_sof", int'(do_sof), 0);
        check("rst_eof", int'(do_eof), 0);
        mon_en = 1'b1;

        // QPSK frame at full rate
        foreach (t1[i]) drive_bit(t1[i], 1'b0);
        idle(2);

        // 16-QAM frame: two directed symbols, padded with random bits to close the frame
        foreach (t2[i]) drive_bit(t2[i], 1'b1);
        for (int i = 0; i < 8; i++) drive_bit(1'($urandom_range(0, 1)), 1'b1);
        idle(2);

        // Mode raised mid-frame must not take effect until the next frame
        for (int i = 0; i < 4; i++) drive_bit(t1[i], 1'b0);
        for (int i = 4; i < 8; i++) drive_bit(t1[i], 1'b1);
        for (int i = 0; i < 16; i++) drive_bit(1'($urandom_range(0, 1)), 1'b1);
        idle(2);

        // QPSK with three idle cycles after every bit
        foreach (t1[i]) begin
            drive_bit(t1[i], 1'b0);
            idle(3);
        end

        // Reset after one bit of a 16-QAM symbol; di_vld asserted with rst must be ignored
        drive_bit(1'b1, 1'b1);
        rst = 1'b1;
        di = 1'b1;
        di_vld = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        di_vld = 1'b0;
        m_in_frame = 1'b0;
        m_bits.delete();
        m_cnt = 0;
        last_re = 0;
        last_im = 0;
        check("rst2_re", int'(do_re), 0);
        check("rst2_im", int'(do_im), 0);
        check("rst2_vld", int'(do_vld), 0);
        check("rst2_flags", int'({do_sof, do_eof}), 0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
        idle(2);

        // Randomized bits, modes and gaps
        for (int i = 0; i < 400; i++) begin
            drive_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        idle(2);
        check("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
